// File: rtl/regb_fifo_packer_pkg.sv
// Shared definitions for the FIFO packer: state encoding and the counter-width helper.
// The helper also sizes FIFO occupancy counters.
package regb_fifo_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/regb_fifo_packer.sv
// Pops WIDTH-bit entries from the register FIFO head and packs RATIO of them per output word.
// A word is offered over valid/ready; flush closes a partial word with its lane count.
module regb_fifo_packer
  import regb_fifo_packer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RATIO = 4,
  parameter int CNT_W = cnt_width(RATIO)
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic [WIDTH-1:0]       fifo_data,
  input  logic                   fifo_empty_n,
  output logic                   fifo_shift_out,
  input  logic                   flush,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_valid,
  input  logic                   out_ready
);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             pop_s;
  logic             lane_clr_s;
  logic [RATIO-1:0] lane_we_s;

  // Pop decision: out_ready reaches the FIFO only while a word is being held.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      FILL:    pop_s = fifo_empty_n;
      HOLD:    pop_s = fifo_empty_n & out_ready;
      default: pop_s = 1'b0;
    endcase
  end

  assign fifo_shift_out = pop_s;
  assign cnt_inc_s      = cnt_r + CNT_W'(pop_s);

  // Next state, lane write enables and word count.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    count_s    = count_r;
    lane_clr_s = 1'b0;
    lane_we_s  = '0;
    case (state_r)
      FILL: begin
        for (int i = 0; i < RATIO; i++) begin
          lane_we_s[i] = pop_s & (cnt_r == CNT_W'(i));
        end
        if (pop_s && (cnt_r == CNT_W'(RATIO - 1))) begin
          state_s = HOLD;
          cnt_s   = '0;
          count_s = CNT_W'(RATIO);
        end else if (flush && (cnt_inc_s != '0)) begin
          state_s = HOLD;
          cnt_s   = '0;
          count_s = cnt_inc_s;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      HOLD: begin
        if (!out_ready) begin
          state_s = HOLD;
        end else begin
          // Accepted word: lanes clear, except lane 0 takes a same-cycle pop.
          lane_clr_s   = 1'b1;
          lane_we_s[0] = pop_s;
          if (pop_s && flush) begin
            state_s = HOLD;
            cnt_s   = '0;
            count_s = CNT_W'(1);
          end else begin
            state_s = FILL;
            cnt_s   = CNT_W'(pop_s);
            count_s = '0;
          end
        end
      end
      default: begin
        state_s    = FILL;
        cnt_s      = '0;
        count_s    = '0;
        lane_clr_s = 1'b1;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r <= FILL;
      cnt_r   <= '0;
      count_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      count_r <= count_s;
    end
  end

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    logic [WIDTH-1:0] lane_r;

    // One lane of the packed word; a write wins over the clear.
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        lane_r <= '0;
      end else if (lane_we_s[g]) begin
        lane_r <= fifo_data;
      end else if (lane_clr_s) begin
        lane_r <= '0;
      end else begin
        lane_r <= lane_r;
      end
    end

    assign out_data[g*WIDTH +: WIDTH] = lane_r;
  end

  assign out_valid = (state_r == HOLD);
  assign out_count = count_r;

endmodule

// File: tb/tb_regb_fifo_packer.sv
// Directed bench for regb_fifo_packer: per-cycle vector table plus async-reset sequences.
module tb_regb_fifo_packer;

  logic        clk;
  logic        res_n;
  logic [3:0]  fifo_data;
  logic        fifo_empty_n;
  logic        fifo_shift_out;
  logic        flush;
  logic [15:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int n_chk;
  int n_fail;

  regb_fifo_packer #(.WIDTH(4), .RATIO(4)) dut (
    .clk            (clk),
    .res_n          (res_n),
    .fifo_data      (fifo_data),
    .fifo_empty_n   (fifo_empty_n),
    .fifo_shift_out (fifo_shift_out),
    .flush          (flush),
    .out_data       (out_data),
    .out_count      (out_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  d;
    logic        fl;
    logic        rdy;
    logic        x_sh;
    logic        x_v;
    logic [15:0] x_data;
    logic [2:0]  x_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic en, logic [3:0] d, logic fl, logic rdy,
                              logic sh, logic v, logic [15:0] data, logic [2:0] c);
    vec_t r;
    r.en = en; r.d = d; r.fl = fl; r.rdy = rdy;
    r.x_sh = sh; r.x_v = v; r.x_data = data; r.x_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational pop, then the registered outputs after the edge.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    fifo_empty_n = v.en;
    fifo_data    = v.d;
    flush        = v.fl;
    out_ready    = v.rdy;
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".shift_out"}, 32'(fifo_shift_out), 32'(v.x_sh));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.x_v));
    if (v.x_v) begin
      chk({tag, ".out_data"}, 32'(out_data), 32'(v.x_data));
      chk({tag, ".out_count"}, 32'(out_count), 32'(v.x_cnt));
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({name, ".out_data"}, 32'(out_data), 32'd0);
    chk({name, ".out_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    n_chk = 0;
    n_fail = 0;
    res_n = 1'b0;
    fifo_data = 4'h0;
    fifo_empty_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;

    // First word 1,2,3,4
    vq.push_back(mk(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4321, 3'd4));
    // Continuous stream 0..F, zero-bubble
    for (int k = 0; k < 16; k++) begin
      w = {4'(k), 4'(k - 1), 4'(k - 2), 4'(k - 3)};
      vq.push_back(mk(1'b1, 4'(k), 1'b0, 1'b1, 1'b1, 1'((k % 4) == 3), w, 3'd4));
    end
    // Backpressure for 5 cycles, then release with same-cycle pop into lane 0
    for (int k = 0; k < 5; k++) begin
      vq.push_back(mk(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFEDC, 3'd4));
    end
    vq.push_back(mk(1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8765, 3'd4));
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0));
    // A,B then flush without pop
    vq.push_back(mk(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00BA, 3'd2));
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0));
    // A,B then flush together with the pop of C
    vq.push_back(mk(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0CBA, 3'd3));
    // Flush while held and not ready: ignored
    vq.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0CBA, 3'd3));
    vq.push_back(mk(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0CBA, 3'd3));
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0));
    // Flush with nothing buffered and empty FIFO: ignored
    vq.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0));
    // Accept + pop + flush in HOLD -> single-entry word
    vq.push_back(mk(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0));
    vq.push_back(mk(1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00BA, 3'd2));
    vq.push_back(mk(1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0007, 3'd1));
    vq.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0));

    // Reset state
    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    res_n = 1'b1;
    check_zero("post_reset");

    foreach (vq[i]) apply(vq[i], i);

    // Async reset with two lanes filled
    apply(mk(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0), 100);
    apply(mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0), 101);
    fifo_empty_n = 1'b0;
    #1;
    res_n = 1'b0;
    #1;
    check_zero("rst_mid_word");
    #2;
    res_n = 1'b1;
    apply(mk(1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0), 102);
    apply(mk(1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0), 103);
    apply(mk(1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0), 104);
    apply(mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6789, 3'd4), 105);

    // Async reset while holding a word
    apply(mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h6789, 3'd4), 106);
    fifo_empty_n = 1'b0;
    #1;
    res_n = 1'b0;
    #1;
    check_zero("rst_mid_hold");
    #2;
    res_n = 1'b1;
    apply(mk(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0), 107);
    apply(mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0), 108);
    apply(mk(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0), 109);
    apply(mk(1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8765, 3'd4), 110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
